// File: rtl/windowed_reg_file_if.sv
// rtl/windowed_reg_file_if.sv - datapath-side bundle of the register-window file ports
interface windowed_reg_file_if #(
  parameter int WIDTH    = 16,
  parameter int WND_BITS = 2
);
  logic [WND_BITS-1:0] wnd;
  logic [1:0]          readReg1;
  logic [1:0]          readReg2;
  logic [1:0]          writeReg;
  logic [WIDTH-1:0]    writeData;
  logic                regWrite;
  logic [WIDTH-1:0]    readData1;
  logic [WIDTH-1:0]    readData2;

  // Datapath side: selects the window and registers, consumes operands
  modport master (
    output wnd, readReg1, readReg2, writeReg, writeData, regWrite,
    input  readData1, readData2
  );

  // Register file side
  modport slave (
    input  wnd, readReg1, readReg2, writeReg, writeData, regWrite,
    output readData1, readData2
  );
endinterface

// File: rtl/windowed_reg_file.sv
// rtl/windowed_reg_file.sv - eight physical registers seen through overlapping 4-register windows
module windowed_reg_file #(
  parameter int WIDTH    = 16,
  parameter int NPHYS    = 8,
  parameter int WND_BITS = 2
) (
  input logic                 clk,
  input logic                 rst,
  windowed_reg_file_if.slave  bus
);

  // Physical storage; NPHYS must be 2**(WND_BITS+1) so the index wraps naturally
  logic [WIDTH-1:0] regs [NPHYS];

  logic [WND_BITS:0] rdIdx1;
  logic [WND_BITS:0] rdIdx2;
  logic [WND_BITS:0] wrIdx;

  // Window w starts at physical 2*w, so R2/R3 of one window alias R0/R1 of the next
  function automatic logic [WND_BITS:0] physIdx(input logic [WND_BITS-1:0] w,
                                                 input logic [1:0] r);
    return {w, 1'b0} + (WND_BITS+1)'(r);
  endfunction

  assign rdIdx1 = physIdx(bus.wnd, bus.readReg1);
  assign rdIdx2 = physIdx(bus.wnd, bus.readReg2);
  assign wrIdx  = physIdx(bus.wnd, bus.writeReg);

  // Operand reads are combinational with no write bypass: the datapath reads before the edge
  assign bus.readData1 = regs[rdIdx1];
  assign bus.readData2 = regs[rdIdx2];

  // Single write port using the window present at the edge; reset clears everything at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPHYS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.regWrite) begin
      regs[wrIdx] <= bus.writeData;
    end
  end

endmodule

// File: tb/tb_windowed_reg_file.sv
// tb/tb_windowed_reg_file.sv - randomized and directed check of windowed_reg_file against a mapping model
module tb_windowed_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;

  windowed_reg_file_if #(.WIDTH(16), .WND_BITS(2)) bus ();

  windowed_reg_file #(.WIDTH(16), .NPHYS(8), .WND_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] model [8];
  int vectorCount = 0;
  int missCount   = 0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int physOf(input int w, input int r);
    return (2 * w + r) % 8;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  task automatic checkReads(input string tag);
    #1;
    checkVal({tag, "/rd1"}, bus.readData1, model[physOf(int'(bus.wnd), int'(bus.readReg1))]);
    checkVal({tag, "/rd2"}, bus.readData2, model[physOf(int'(bus.wnd), int'(bus.readReg2))]);
  endtask

  task automatic sweep(input string tag);
    for (int w = 0; w < 4; w++) begin
      for (int r = 0; r < 4; r++) begin
        bus.wnd      = 2'(w);
        bus.readReg1 = 2'(r);
        bus.readReg2 = 2'(3 - r);
        checkReads($sformatf("%s/w%0d/r%0d", tag, w, r));
      end
    end
  endtask

  task automatic doWrite(input int w, input int r, input logic [15:0] d, input logic en);
    @(negedge clk);
    bus.wnd       = 2'(w);
    bus.writeReg  = 2'(r);
    bus.writeData = d;
    bus.regWrite  = en;
    @(posedge clk);
    if (en) model[physOf(w, r)] = d;
    #1;
    bus.regWrite = 1'b0;
  endtask

  initial begin
    logic [15:0] oldP0;
    int w;
    int r;
    logic [15:0] d;
    logic en;

    bus.wnd       = '0;
    bus.readReg1  = '0;
    bus.readReg2  = '0;
    bus.writeReg  = '0;
    bus.writeData = '0;
    bus.regWrite  = 1'b0;
    clearModel();

    #2 rst = 1'b0;
    #10 rst = 1'b1;
    sweep("reset_init");

    // Preload every physical register with a distinct nonzero value
    for (int i = 0; i < 4; i++) doWrite(0, i, 16'h1001 + 16'(i), 1'b1);
    for (int i = 0; i < 4; i++) doWrite(2, i, 16'h1005 + 16'(i), 1'b1);
    @(negedge clk);
    sweep("preload");

    // Reset mid-cycle while a write is being attempted; reset must win across edges
    @(negedge clk);
    #2;
    bus.wnd       = 2'd1;
    bus.writeReg  = 2'd0;
    bus.writeData = 16'hFFFF;
    bus.regWrite  = 1'b1;
    rst           = 1'b0;
    clearModel();
    sweep("reset_live");
    @(negedge clk);
    bus.regWrite = 1'b0;
    #2 rst = 1'b1;

    // Basic write/read
    doWrite(0, 1, 16'h1234, 1'b1);
    bus.wnd = 2'd0; bus.readReg1 = 2'd1; bus.readReg2 = 2'd0;
    #1;
    checkVal("basic_r1", bus.readData1, 16'h1234);
    checkVal("basic_r2", bus.readData2, 16'h0000);

    // Overlap between windows 1 and 2
    doWrite(1, 3, 16'hBEEF, 1'b1);
    bus.wnd = 2'd2; bus.readReg1 = 2'd1;
    #1 checkVal("overlap_w2r1", bus.readData1, 16'hBEEF);
    bus.wnd = 2'd1; bus.readReg1 = 2'd3;
    #1 checkVal("overlap_w1r3", bus.readData1, 16'hBEEF);

    // Wrap from window 3 into window 0
    doWrite(3, 2, 16'hA5A5, 1'b1);
    doWrite(3, 3, 16'h5A5A, 1'b1);
    bus.wnd = 2'd0; bus.readReg1 = 2'd0; bus.readReg2 = 2'd1;
    #1;
    checkVal("wrap_r0", bus.readData1, 16'hA5A5);
    checkVal("wrap_r1", bus.readData2, 16'h5A5A);

    // Read during write, then the same with the enable low
    doWrite(2, 0, 16'h0001, 1'b1);
    @(negedge clk);
    bus.wnd = 2'd2; bus.writeReg = 2'd0; bus.writeData = 16'h00FF;
    bus.regWrite = 1'b1; bus.readReg1 = 2'd0;
    #1 checkVal("rdw_before", bus.readData1, 16'h0001);
    @(posedge clk);
    model[4] = 16'h00FF;
    #1 checkVal("rdw_after", bus.readData1, 16'h00FF);
    @(negedge clk);
    bus.writeData = 16'h0BAD; bus.regWrite = 1'b0;
    #1 checkVal("nowr_before", bus.readData1, 16'h00FF);
    @(posedge clk);
    #1 checkVal("nowr_after", bus.readData1, 16'h00FF);

    // Window switch coincident with the write edge
    oldP0 = model[0];
    @(negedge clk);
    bus.wnd = 2'd0; bus.writeReg = 2'd0; bus.writeData = 16'h7777; bus.regWrite = 1'b1;
    #2 bus.wnd = 2'd1;
    @(posedge clk);
    model[2] = 16'h7777;
    #1 bus.regWrite = 1'b0;
    bus.wnd = 2'd1; bus.readReg1 = 2'd0;
    #1 checkVal("wswitch_w1r0", bus.readData1, 16'h7777);
    bus.wnd = 2'd0;
    #1 checkVal("wswitch_w0r0", bus.readData1, oldP0);

    @(negedge clk);
    sweep("directed_end");

    // Randomized traffic, checking both before and after each edge
    for (int n = 0; n < 300; n++) begin
      w  = int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 3));
      d  = 16'($urandom);
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.wnd = 2'(w); bus.writeReg = 2'(r); bus.writeData = d; bus.regWrite = en;
      bus.readReg1 = 2'(r); bus.readReg2 = 2'($urandom_range(0, 3));
      checkReads($sformatf("rand%0d_pre", n));
      @(posedge clk);
      if (en) model[physOf(w, r)] = d;
      checkReads($sformatf("rand%0d_post", n));
    end
    @(negedge clk);
    bus.regWrite = 1'b0;
    sweep("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
